// File: rtl/get_cube_pkg.sv
// cube_pkg: sine table, point/edge types and the edge-to-vertex table for get_cube.
package cube_pkg;
  localparam int NUM_LINES = 12;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } point_t;
  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
  } edge_t;
  // round(32768*sin(d)) for d = 0..90 degrees; 90 degrees is exactly 1.0
  localparam logic [15:0] SIN_Q15 [0:90] = '{
    16'd0,     16'd572,   16'd1144,  16'd1715,  16'd2286,  16'd2856,  16'd3425,
    16'd3993,  16'd4560,  16'd5126,  16'd5690,  16'd6252,  16'd6813,  16'd7371,
    16'd7927,  16'd8481,  16'd9032,  16'd9580,  16'd10126, 16'd10668, 16'd11207,
    16'd11743, 16'd12275, 16'd12803, 16'd13328, 16'd13848, 16'd14365, 16'd14876,
    16'd15384, 16'd15886, 16'd16384, 16'd16877, 16'd17364, 16'd17847, 16'd18324,
    16'd18795, 16'd19261, 16'd19720, 16'd20174, 16'd20622, 16'd21063, 16'd21498,
    16'd21926, 16'd22348, 16'd22763, 16'd23170, 16'd23571, 16'd23965, 16'd24351,
    16'd24730, 16'd25102, 16'd25466, 16'd25822, 16'd26170, 16'd26510, 16'd26842,
    16'd27166, 16'd27482, 16'd27789, 16'd28088, 16'd28378, 16'd28660, 16'd28933,
    16'd29197, 16'd29452, 16'd29698, 16'd29935, 16'd30163, 16'd30382, 16'd30592,
    16'd30792, 16'd30983, 16'd31164, 16'd31336, 16'd31499, 16'd31652, 16'd31795,
    16'd31928, 16'd32052, 16'd32166, 16'd32270, 16'd32365, 16'd32449, 16'd32524,
    16'd32589, 16'd32643, 16'd32688, 16'd32723, 16'd32748, 16'd32763, 16'd32768
  };
  // vertex indices 0..3 are the front face F0..F3, 4..7 the back face B0..B3
  localparam edge_t EDGES [0:NUM_LINES-1] = '{
    '{3'd0, 3'd1}, '{3'd1, 3'd2}, '{3'd2, 3'd3}, '{3'd3, 3'd0},
    '{3'd4, 3'd5}, '{3'd5, 3'd6}, '{3'd6, 3'd7}, '{3'd7, 3'd4},
    '{3'd0, 3'd4}, '{3'd1, 3'd5}, '{3'd2, 3'd6}, '{3'd3, 3'd7}
  };
endpackage

// File: rtl/get_cube.sv
// get_cube: registered endpoint lookup for the 12 edges of an oblique-projected cube.
module get_cube
  import cube_pkg::*;
#(
  parameter int WIDTH = 100,
  parameter int HEIGHT = 100,
  parameter int DEPTH = 5,
  parameter int ADJ_DEG = 45,
  parameter int SCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] line_id,
  output logic [15:0] x0,
  output logic [15:0] y0,
  output logic [15:0] x1,
  output logic [15:0] y1
);
  localparam int ANG = (ADJ_DEG < 0 || ADJ_DEG > 90) ? 0 : ADJ_DEG;
  localparam int DX = (DEPTH * SCALE * int'(SIN_Q15[90-ANG]) + 16384) >>> 15;
  localparam int DY = (DEPTH * SCALE * int'(SIN_Q15[ANG]) + 16384) >>> 15;
  localparam int W = WIDTH * SCALE;
  localparam int H = HEIGHT * SCALE;
  localparam int VX [0:7] = '{0, W, W, 0, DX, DX + W, DX + W, DX};
  localparam int VY [0:7] = '{DY, DY, DY + H, DY + H, 0, 0, H, H};
  if (ADJ_DEG < 0 || ADJ_DEG > 90 || WIDTH == 0 || HEIGHT == 0 || SCALE == 0 ||
      DX + W > 65535 || DY + H > 65535) begin : g_bad
    $error("get_cube: illegal parameters or coordinates exceed 16 bits");
  end
  logic valid;
  edge_t e;
  point_t p0, p1;
  always_comb begin
    valid = line_id < 32'(NUM_LINES);
    e = valid ? EDGES[line_id[3:0]] : '0;
    p0 = '{16'(VX[e.a]), 16'(VY[e.a])};
    p1 = '{16'(VX[e.b]), 16'(VY[e.b])};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) {x0, y0, x1, y1} <= '0;
    else if (valid) {x0, y0, x1, y1} <= {p0.x, p0.y, p1.x, p1.y};
    else {x0, y0, x1, y1} <= '0;
endmodule

// File: tb/tb_get_cube.sv
// tb_get_cube: scoreboard bench over three get_cube parameterisations.
module tb_get_cube;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] line_id = '0;
  logic [15:0] ax0, ay0, ax1, ay1, bx0, by0, bx1, by1, cx0, cy0, cx1, cy1;
  int compared = 0;
  int mismatched = 0;
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  get_cube u_def (.clk(clk), .rst(rst), .line_id(line_id), .x0(ax0), .y0(ay0), .x1(ax1), .y1(ay1));
  get_cube #(.ADJ_DEG(0)) u_flat (.clk(clk), .rst(rst), .line_id(line_id), .x0(bx0), .y0(by0), .x1(bx1), .y1(by1));
  get_cube #(.SCALE(2)) u_x2 (.clk(clk), .rst(rst), .line_id(line_id), .x0(cx0), .y0(cy0), .x1(cx1), .y1(cy1));

  wire logic [63:0] oa = {ax0, ay0, ax1, ay1};
  wire logic [63:0] ob = {bx0, by0, bx1, by1};
  wire logic [63:0] oc = {cx0, cy0, cx1, cy1};

  function automatic logic [63:0] model(input int w, input int h, input int dx, input int dy,
                                        input logic [31:0] id);
    int fx [4];
    int fy [4];
    int px [8];
    int py [8];
    int a, b;
    fx = '{0, w, w, 0};
    fy = '{dy, dy, dy + h, dy + h};
    for (int i = 0; i < 4; i++) begin
      px[i] = fx[i];
      py[i] = fy[i];
      px[i+4] = fx[i] + dx;
      py[i+4] = fy[i] - dy;
    end
    if (id >= 32'd12) return '0;
    if (id < 32'd4) begin
      a = int'(id);
      b = (a + 1) % 4;
    end else if (id < 32'd8) begin
      a = int'(id);
      b = 4 + (a - 3) % 4;
    end else begin
      a = int'(id) - 8;
      b = a + 4;
    end
    return {16'(px[a]), 16'(py[a]), 16'(px[b]), 16'(py[b])};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] id);
    exp_t x;
    x.a = model(100, 100, 4, 4, id);
    x.b = model(100, 100, 5, 0, id);
    x.c = model(200, 200, 7, 7, id);
    sb.push_back(x);
  endtask

  task automatic pop_check(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      check({tag, "_empty"}, 64'd1, 64'd0);
      return;
    end
    x = sb.pop_front();
    check({tag, "_def"}, oa, x.a);
    check({tag, "_adj0"}, ob, x.b);
    check({tag, "_x2"}, oc, x.c);
  endtask

  task automatic step(input logic [31:0] id, input string tag);
    line_id = id;
    push(id);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  initial begin
    #2;
    check("rst_def", oa, 64'd0);
    check("rst_adj0", ob, 64'd0);
    check("rst_x2", oc, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(32'd0, "def_id0");
    check("lit_def_id0", oa, {16'd0, 16'd4, 16'd100, 16'd4});
    step(32'd5, "def_id5");
    check("lit_def_id5", oa, {16'd104, 16'd0, 16'd104, 16'd100});
    step(32'd9, "def_id9");
    check("lit_def_id9", oa, {16'd100, 16'd4, 16'd104, 16'd0});
    step(32'd8, "adj0_id8");
    check("lit_adj0_id8", ob, {16'd0, 16'd0, 16'd5, 16'd0});
    step(32'd1, "x2_id1");
    check("lit_x2_id1", oc, {16'd200, 16'd7, 16'd200, 16'd207});
    step(32'hFFFF_FFFF, "sweep_ff");
    for (int i = 0; i < 12; i++) step(32'(i), $sformatf("sweep_%0d", i));
    step(32'd12, "sweep_12");
    step(32'd16, "alias_16");
    step(32'd28, "alias_28");
    step(32'h8000_0003, "alias_hi");
    step(32'd11, "b2b_11");
    step(32'd3, "b2b_3");
    line_id = 32'd7;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_def", oa, 64'd0);
    check("midrst_adj0", ob, 64'd0);
    check("midrst_x2", oc, 64'd0);
    @(posedge clk);
    #1;
    check("heldrst_def", oa, 64'd0);
    rst = 1'b0;
    line_id = 32'd10;
    step(32'd10, "post_rst_10");
    step(32'd6, "post_rst_6");
    for (int i = 0; i < 6; i++) step($urandom_range(0, 15), $sformatf("rnd_%0d", i));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/get_cube.md
GET_CUBE -- requirements
Module: get_cube

Interface
REQ-001 SHALL have parameter WIDTH, default 100: cube front-face width in pixels before scaling, integer >= 1.
REQ-002 SHALL have parameter HEIGHT, default 100: front-face height in pixels before scaling, integer >= 1.
REQ-003 SHALL have parameter DEPTH, default 5: receding-edge length in pixels before scaling, integer >= 0.
REQ-004 SHALL have parameter ADJ_DEG, default 45: oblique projection angle in whole degrees, legal range 0..90.
REQ-005 SHALL have parameter SCALE, default 1: integer multiplier on all three dimensions, >= 1.
REQ-006 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port line_id, input, 32 bits: unsigned index of the cube edge requested.
REQ-009 SHALL have port x0, output, 16 bits: unsigned screen X of the edge start point.
REQ-010 SHALL have port y0, output, 16 bits: unsigned screen Y of the edge start point, Y increasing downward.
REQ-011 SHALL have port x1, output, 16 bits: unsigned screen X of the edge end point.
REQ-012 SHALL have port y1, output, 16 bits: unsigned screen Y of the edge end point.

Function
REQ-013 SHALL compute at elaboration DX = round(DEPTH*SCALE*cos(ADJ_DEG)) and DY = round(DEPTH*SCALE*sin(ADJ_DEG)), using a Q1.15 sine table (entries 0..90) and rounding by adding 2^14 before the 15-bit right shift.
REQ-014 SHALL use W = WIDTH*SCALE and H = HEIGHT*SCALE for the scaled face size.
REQ-015 SHALL place front vertices F0=(0,DY), F1=(W,DY), F2=(W,DY+H) and F3=(0,DY+H).
REQ-016 SHALL place back vertices Bi = Fi + (DX,-DY) for i = 0..3.
REQ-017 SHALL map the 12 edges as: id 0..3 = F0-F1, F1-F2, F2-F3, F3-F0; id 4..7 = B0-B1, B1-B2, B2-B3, B3-B0; id 8..11 = F0-B0, F1-B1, F2-B2, F3-B3.
REQ-018 SHALL register outputs with 1-cycle latency: the edge selected by line_id before rising edge N appears on x0/y0/x1/y1 after that edge.
REQ-019 SHALL drive all four outputs to 0 on the next edge when line_id >= 12, including 0xFFFFFFFF.
REQ-020 SHALL compare the full 32-bit line_id with no truncation, so that id 12+k never aliases to a valid edge.
REQ-021 SHALL have no handshake: a new line_id is accepted every cycle, and changing line_id every cycle yields back-to-back results.
REQ-022 SHALL raise an elaboration error ($error) if ADJ_DEG lies outside 0..90, WIDTH, HEIGHT or SCALE is 0, or any of DX+W and DY+H exceeds 65535.
REQ-023 SHALL compute all vertex arithmetic at 32 bits and truncate to 16 bits only at the output registers, after REQ-022 guarantees the values fit.

Reset
REQ-024 SHALL force x0, y0, x1 and y1 to 0 immediately while rst is high, independent of clk.
REQ-025 SHALL, on the first rising clk edge after rst falls, present the edge for the current line_id.
REQ-026 SHALL abandon any pending result if rst asserts mid-operation.

Structure
REQ-027 SHALL place in package cube_pkg: the 91-entry Q1.15 sine table, constant NUM_LINES=12, a typedef for a 16-bit point {x,y}, and the 12-entry edge-to-vertex-index table.
REQ-028 SHALL be a single module with no sub-module; vertex coordinates are localparams and edge selection is a 12-way case/mux into the output registers.

Verification
REQ-029 SHALL cover defaults (100,100,5,45,1): DX=DY=4; line_id 0 -> (0,4)-(100,4); line_id 5 -> (104,0)-(104,100); line_id 9 -> (100,4)-(104,0).
REQ-030 SHALL cover sweeping line_id 0xFFFFFFFF, 0..11, 12 on successive cycles -> zeros, then the 12 edges in REQ-017 order each 1 cycle later, then zeros.
REQ-031 SHALL cover ADJ_DEG=0, DEPTH=5 -> DX=5, DY=0; line_id 8 -> (0,0)-(5,0).
REQ-032 SHALL cover SCALE=2 with defaults -> DX=DY=7; line_id 1 -> (200,7)-(200,207).
REQ-033 SHALL cover rst asserted mid-sweep (between clk edges) -> outputs 0 at once, and the first edge after release shows the current line_id's edge.
REQ-034 SHALL cover WIDTH=65535 -> elaboration error.
